// File: rtl/bram_burst_master_pkg.sv
// Shared constants and helpers for the BRAM burst master and its read skid buffer.
// Holds only the skid-buffer sizing and the read-issue admission rule.
package bram_burst_master_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CW    = 2;

    // A read may be issued only if, after this cycle's pop, at most one word
    // is buffered or in flight, so the returning word always has a free slot.
    function automatic logic issue_ok(
        input logic [SKID_CW-1:0] count,
        input logic               inflight,
        input logic               pop
    );
        logic [SKID_CW:0] occ;
        occ = {1'b0, count} + {{SKID_CW{1'b0}}, inflight} - {{SKID_CW{1'b0}}, pop};
        return occ <= 3'd1;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO that catches BRAM read data the cycle after each read issue.
// The head word is presented combinationally; count reports 0..2 entries.
module bram_rd_skid
    import bram_burst_master_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DW-1:0]      push_data,
    input  logic               pop,
    output logic [SKID_CW-1:0] count,
    output logic [DW-1:0]      head_data
);

    logic [DW-1:0] mem [SKID_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign pop_en  = pop && (count != '0);
    assign push_en = push && ((count != 2'd2) || pop_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= ~wr_ptr;
            if (pop_en)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_en} - {1'b0, pop_en};
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/bram_burst_master.sv
// Burst master driving one BRAM port: write bursts from a valid/ready stream,
// read bursts into a valid/ready stream through a two-entry skid buffer.
module bram_burst_master
    import bram_burst_master_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    output logic          WE,
    output logic [DW-1:0] WEM,
    output logic          CE,
    input  logic [DW-1:0] Q
);

    // state   | meaning
    // S_IDLE  | waiting for a command; cmd_ready high, BRAM idle
    // S_WRITE | one BRAM write per accepted wr_data word
    // S_READ  | issuing reads and draining the skid buffer to rd_*
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    localparam logic [AW:0]   ONE_CNT  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_ADDR = {{(AW-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_n;
    logic [AW-1:0]       addr;
    logic [AW:0]         beat_cnt;
    logic [AW:0]         iss_cnt;
    logic                inflight;
    logic                done_q;
    logic [SKID_CW-1:0]  fifo_count;
    logic [DW-1:0]       fifo_head;

    logic cmd_hs;
    logic wr_beat;
    logic pop;
    logic issue;
    logic last_beat;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        wr_beat   = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        last_beat = 1'b0;
        cmd_hs    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                cmd_hs    = cmd_valid;
                if (cmd_valid) state_n = cmd_write ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                wr_ready  = 1'b1;
                wr_beat   = wr_valid;
                last_beat = wr_valid && (beat_cnt == ONE_CNT);
                if (last_beat) state_n = S_IDLE;
            end
            S_READ: begin
                rd_valid  = (fifo_count != '0);
                pop       = rd_valid && rd_ready;
                issue     = (iss_cnt != '0) && issue_ok(fifo_count, inflight, pop);
                last_beat = pop && (beat_cnt == ONE_CNT);
                if (last_beat) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // beat_cnt counts down write beats or read handshakes; iss_cnt counts
    // down read issues, which run ahead of the handshakes by up to two words.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr     <= '0;
            beat_cnt <= '0;
            iss_cnt  <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= last_beat;
            inflight <= issue;
            if (cmd_hs) begin
                addr     <= cmd_addr;
                beat_cnt <= {1'b0, cmd_len} + ONE_CNT;
                iss_cnt  <= cmd_write ? '0 : ({1'b0, cmd_len} + ONE_CNT);
            end else begin
                if (wr_beat || issue) addr     <= addr + ONE_ADDR;
                if (wr_beat || pop)   beat_cnt <= beat_cnt - ONE_CNT;
                if (issue)            iss_cnt  <= iss_cnt - ONE_CNT;
            end
        end
    end

    bram_rd_skid #(
        .DW(DW)
    ) u_rd_skid (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data (Q),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign rd_data = fifo_head;
    assign done    = done_q;
    assign A       = addr;
    assign D       = wr_data;
    assign WE      = wr_beat;
    assign CE      = wr_beat || issue;
    assign WEM     = wr_beat ? '1 : '0;

endmodule

// File: tb/tb_bram_burst_master.sv
// Bench for bram_burst_master: directed bursts then random bursts, checked
// against an array model of BRAM contents and the stream/latency rules.
module tb_bram_burst_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr, cmd_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        done;
    logic [9:0]  A;
    logic [15:0] D;
    logic        WE;
    logic [15:0] WEM;
    logic        CE;
    logic [15:0] Q = 16'h0;

    logic [15:0] bram  [1024] = '{default: 16'h0};
    logic [15:0] model [1024] = '{default: 16'h0};

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int t_first_ce, t_first_valid, t_last_pop, t_done;

    always #5 CLK = ~CLK;

    bram_burst_master #(.AW(10), .DW(16)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .A(A), .D(D), .WE(WE), .WEM(WEM), .CE(CE), .Q(Q)
    );

    always @(posedge CLK) begin
        if (CE) begin
            if (WE) bram[A] <= D;
            else    Q <= bram[A];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input bit wr, input int addr, input int len);
        int guard = 0;
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = 10'(addr);
        cmd_len   = 10'(len);
        #1;
        while (!cmd_ready && guard < 50) begin
            @(negedge CLK); #1;
            guard++;
        end
        chk("cmd_ready_at_cmd", cmd_ready, 1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input int addr, input int len, input int vpct, input int dbase);
        int beats = 0;
        int cyc   = 0;
        int ea;
        do_cmd(1'b1, addr, len);
        while (beats <= len && cyc < 4 * (len + 1) + 50) begin
            @(negedge CLK);
            wr_valid = ($urandom_range(99) < vpct);
            wr_data  = (dbase >= 0) ? 16'(dbase + beats) : 16'($urandom);
            #1;
            cyc++;
            chk("wr_ready", wr_ready, 1);
            chk("wr_done_early", done, 0);
            if (wr_valid) begin
                ea = (addr + beats) % 1024;
                chk("wr_ce", CE, 1);
                chk("wr_we", WE, 1);
                chk("wr_wem", WEM, 16'hFFFF);
                chk("wr_addr", A, ea);
                chk("wr_d", D, wr_data);
                model[ea] = wr_data;
                beats++;
            end else begin
                chk("wr_ce_idle", CE, 0);
                chk("wr_wem_zero", WEM, 0);
            end
            @(posedge CLK);
        end
        @(negedge CLK);
        wr_valid = 1'b0;
        #1;
        cyc++;
        t_done = cyc;
        chk("wr_beats", beats, len + 1);
        chk("wr_done", done, 1);
        chk("wr_back_idle", cmd_ready, 1);
        chk("wr_ready_idle", wr_ready, 0);
        chk("wr_ce_after", CE, 0);
    endtask

    task automatic run_read(input int addr, input int len, input int mode, input int abort_after);
        int issued = 0;
        int popped = 0;
        int cyc    = 0;
        int outst;
        bit p;
        t_first_ce = -1; t_first_valid = -1; t_last_pop = -1; t_done = -1;
        do_cmd(1'b0, addr, len);
        while (popped <= len && cyc < 8 * (len + 1) + 50) begin
            @(negedge CLK);
            if (abort_after >= 0 && popped == abort_after) begin
                #2;
                RST = 1'b1;
                #1;
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_ce", CE, 0);
                chk("rst_we", WE, 0);
                chk("rst_wr_ready", wr_ready, 0);
                chk("rst_rd_valid", rd_valid, 0);
                chk("rst_done", done, 0);
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                RST = 1'b0;
                rd_ready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge CLK); #1;
                    chk("post_rst_done", done, 0);
                    chk("post_rst_rd_valid", rd_valid, 0);
                    chk("post_rst_ce", CE, 0);
                    chk("post_rst_cmd_ready", cmd_ready, 1);
                end
                rd_ready = 1'b0;
                return;
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 2 == 0);
                default: rd_ready = 1'($urandom_range(1));
            endcase
            #1;
            cyc++;
            outst = issued - popped;
            p = rd_valid && rd_ready;
            chk("rd_outstanding_le2", outst <= 2, 1);
            chk("rd_we_zero", WE, 0);
            chk("rd_wem_zero", WEM, 0);
            chk("rd_done_early", done, 0);
            chk("rd_wr_ready", wr_ready, 0);
            if (rd_valid && t_first_valid < 0) t_first_valid = cyc;
            if (CE) begin
                if (t_first_ce < 0) t_first_ce = cyc;
                chk("rd_issue_gate", (outst - int'(p)) <= 1, 1);
                chk("rd_issue_count", issued <= len, 1);
                chk("rd_addr", A, (addr + issued) % 1024);
                issued++;
            end
            if (p) begin
                chk("rd_data", rd_data, model[(addr + popped) % 1024]);
                popped++;
                t_last_pop = cyc;
            end
            @(posedge CLK);
        end
        @(negedge CLK);
        rd_ready = 1'b0;
        #1;
        cyc++;
        t_done = cyc;
        chk("rd_words", popped, len + 1);
        chk("rd_done", done, 1);
        chk("rd_back_idle", cmd_ready, 1);
        chk("rd_valid_idle", rd_valid, 0);
        chk("rd_ce_after", CE, 0);
    endtask

    initial begin
        int pcount;
        bit seen_done;
        int ra, rl;

        RST = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(negedge CLK); #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_ce", CE, 0);
        chk("reset_we", WE, 0);
        chk("reset_wr_ready", wr_ready, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_done", done, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Write 0xA000..0xA003 at 0x010, then read them back at full rate.
        run_write(16'h010, 3, 100, 16'hA000);
        chk("wr_done_cycle", t_done, 5);
        run_read(16'h010, 3, 0, -1);
        chk("rd_first_ce_cycle", t_first_ce, 1);
        chk("rd_first_valid_cycle", t_first_valid, 3);
        chk("rd_last_pop_cycle", t_last_pop, 6);
        chk("rd_done_cycle", t_done, 7);

        // Eight words read with rd_ready toggling.
        run_write(16'h200, 7, 100, -1);
        run_read(16'h200, 7, 1, -1);

        // Address wrap on write and read-back.
        run_write(16'h3FE, 3, 100, 16'hC000);
        run_read(16'h3FE, 3, 2, -1);
        chk("wrap_word0", model[10'h3FE], 16'hC000);
        chk("wrap_word2", model[10'h000], 16'hC002);

        // Reset in the middle of a 5-word read.
        run_write(16'h050, 4, 100, -1);
        run_read(16'h050, 4, 0, 2);

        // Back-to-back: write then read with cmd_valid held high throughout.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h120; cmd_len = 10'd1;
        wr_valid = 1'b1; wr_data = 16'h5A5A;
        #1;
        chk("b2b_cmd_ready", cmd_ready, 1);
        @(posedge CLK); #1;
        cmd_write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            wr_data = 16'(16'h5A5A + k);
            #1;
            chk("b2b_wr_ce", CE, 1);
            chk("b2b_wr_addr", A, 10'h120 + k);
            chk("b2b_busy", cmd_ready, 0);
            model[10'h120 + k] = wr_data;
            @(posedge CLK);
        end
        @(negedge CLK);
        wr_valid = 1'b0;
        #1;
        chk("b2b_done", done, 1);
        chk("b2b_ready_in_done", cmd_ready, 1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(negedge CLK);
        rd_ready = 1'b1;
        #1;
        chk("b2b_second_ce", CE, 1);
        chk("b2b_second_we", WE, 0);
        chk("b2b_second_addr", A, 10'h120);
        pcount = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            @(negedge CLK); #1;
            if (done) seen_done = 1'b1;
            if (rd_valid && rd_ready && pcount < 2) begin
                chk("b2b_rd_data", rd_data, model[10'h120 + pcount]);
                pcount++;
            end
        end
        rd_ready = 1'b0;
        chk("b2b_rd_words", pcount, 2);
        chk("b2b_rd_done_seen", seen_done, 1);

        // Random bursts, biased toward the top of the address space.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(1023);
            if ($urandom_range(3) == 0) ra = 1016 + $urandom_range(7);
            rl = ($urandom_range(7) == 0) ? $urandom_range(63) : $urandom_range(15);
            if ($urandom_range(1) == 1)
                run_write(ra, rl, $urandom_range(100, 30), -1);
            else
                run_read(ra, rl, $urandom_range(2), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
